dcache_line_mem_responder: RTL and testbench

//  Memory-side responder for D-cache line traffic: the far end of the cache's

---
 rtl/dcache_line_mem_responder_if.sv | 31 +++
 rtl/dcache_line_mem_responder.sv | 173 +++++++++++++++++
 tb/tb_dcache_line_mem_responder.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_line_mem_responder_if.sv
// rtl/dcache_line_mem_responder_if.sv - request, writeback-beat and refill-beat bundle between D-cache and memory responder
interface dcache_line_mem_responder_if #(
  parameter int ADDR_W     = 32,
  parameter int WORD_BYTES = 4
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [ADDR_W-1:0]         req_addr;
  logic                      wdata_valid;
  logic                      wdata_ready;
  logic [8*WORD_BYTES-1:0]   wdata;
  logic [WORD_BYTES-1:0]     wstrb;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [8*WORD_BYTES-1:0]   rsp_data;
  logic                      rsp_last;
  logic                      wr_done;

  // Cache side: issues line requests and writeback beats, consumes refill beats.
  modport master (
    output req_valid, req_we, req_addr, wdata_valid, wdata, wstrb, rsp_ready,
    input  req_ready, wdata_ready, rsp_valid, rsp_data, rsp_last, wr_done
  );

  // Memory side: the responder.
  modport slave (
    input  req_valid, req_we, req_addr, wdata_valid, wdata, wstrb, rsp_ready,
    output req_ready, wdata_ready, rsp_valid, rsp_data, rsp_last, wr_done
  );
endinterface

// File: rtl/dcache_line_mem_responder.sv
// rtl/dcache_line_mem_responder.sv - main-memory model serving D-cache line refills and writebacks
module dcache_line_mem_responder #(
  parameter int LINE_BYTES = 32,
  parameter int WORD_BYTES = 4,
  parameter int ADDR_W     = 32,
  parameter int MEM_LINES  = 1024,
  parameter int READ_LAT   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  dcache_line_mem_responder_if.slave     bus
);
  localparam int WORDS_PER_LINE = LINE_BYTES / WORD_BYTES;
  localparam int DATA_W         = 8 * WORD_BYTES;
  localparam int OFF_BITS       = $clog2(LINE_BYTES);
  localparam int IDX_W          = $clog2(MEM_LINES);
  localparam int BEAT_W         = $clog2(WORDS_PER_LINE);
  localparam int SLOT_W         = IDX_W + BEAT_W;
  localparam int LAT_W          = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int LAT_INIT       = (READ_LAT > 0) ? READ_LAT - 1 : 0;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_BURST,
    S_WR_BURST,
    S_WR_ACK
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    line_q, line_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic                req_ready_q, req_ready_d;
  logic                wdata_ready_q, wdata_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_last_q, rsp_last_d;
  logic                wr_done_q, wr_done_d;

  // Backing store; deliberately never reset so contents survive a burst abort.
  logic [DATA_W-1:0]   mem_q [MEM_LINES*WORDS_PER_LINE];

  logic                req_hs;
  logic                rsp_hs;
  logic                wr_hs;
  logic [SLOT_W-1:0]   wr_slot;
  logic                addr_unused;

  assign req_hs  = bus.req_valid && req_ready_q;
  assign rsp_hs  = rsp_valid_q && bus.rsp_ready;
  assign wr_hs   = bus.wdata_valid && wdata_ready_q;
  assign wr_slot = {line_q, beat_q};

  // Tag bits above the store and the in-line offset only alias onto the same line.
  assign addr_unused = ^{bus.req_addr[ADDR_W-1:OFF_BITS+IDX_W], bus.req_addr[OFF_BITS-1:0]};

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    beat_d     = beat_q;
    lat_d      = lat_q;
    rsp_data_d = rsp_data_q;
    rsp_last_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_hs) begin
          line_d = bus.req_addr[OFF_BITS +: IDX_W];
          beat_d = '0;
          if (bus.req_we) begin
            state_d = S_WR_BURST;
          end else if (READ_LAT > 0) begin
            state_d = S_RD_WAIT;
            lat_d   = LAT_W'(LAT_INIT);
          end else begin
            state_d = S_RD_BURST;
          end
        end
      end
      S_RD_WAIT: begin
        if (lat_q == '0) begin
          state_d = S_RD_BURST;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      S_RD_BURST: begin
        if (rsp_hs) begin
          if (beat_q == LAST_BEAT) begin
            state_d = S_IDLE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      S_WR_BURST: begin
        if (wr_hs) begin
          if (beat_q == LAST_BEAT) begin
            state_d = S_WR_ACK;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      S_WR_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_ready_d   = (state_d == S_IDLE);
    wdata_ready_d = (state_d == S_WR_BURST);
    rsp_valid_d   = (state_d == S_RD_BURST);
    wr_done_d     = (state_d == S_WR_ACK);

    // Fetch the word for the beat about to be presented; a stalled beat re-reads
    // the same slot, which cannot change during a read, so the data holds.
    if (state_d == S_RD_BURST) begin
      rsp_data_d = mem_q[{line_d, beat_d}];
      rsp_last_d = (beat_d == LAST_BEAT);
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      line_q        <= '0;
      beat_q        <= '0;
      lat_q         <= '0;
      req_ready_q   <= 1'b1;
      wdata_ready_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_last_q    <= 1'b0;
      wr_done_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_q        <= line_d;
      beat_q        <= beat_d;
      lat_q         <= lat_d;
      req_ready_q   <= req_ready_d;
      wdata_ready_q <= wdata_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_last_q    <= rsp_last_d;
      wr_done_q     <= wr_done_d;
    end
  end

  // Byte-strobed store update on each accepted writeback beat; suppressed under reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_hs) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (bus.wstrb[b]) begin
          mem_q[wr_slot][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.wdata_ready = wdata_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_last    = rsp_last_q;
  assign bus.wr_done     = wr_done_q;
endmodule

// File: tb/tb_dcache_line_mem_responder.sv
// tb/tb_dcache_line_mem_responder.sv - randomized self-checking bench for the D-cache memory responder
module tb_dcache_line_mem_responder;
  logic        clk;
  logic        rst;
  logic        sel;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic        wdata_valid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        rsp_ready;

  logic        req_ready_o;
  logic        wdata_ready_o;
  logic        rsp_valid_o;
  logic [31:0] rsp_data_o;
  logic        rsp_last_o;
  logic        wr_done_o;

  int          n_checks;
  int          n_pass;

  logic [31:0] mem_m [2][8192];
  logic [31:0] wd [8];
  logic [3:0]  ws [8];
  logic [31:0] rd_beats [8];

  dcache_line_mem_responder_if #(.ADDR_W(32), .WORD_BYTES(4)) bus4 ();
  dcache_line_mem_responder_if #(.ADDR_W(32), .WORD_BYTES(4)) bus0 ();

  dcache_line_mem_responder #(.READ_LAT(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
  dcache_line_mem_responder #(.READ_LAT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

  assign bus4.req_valid   = req_valid & ~sel;
  assign bus0.req_valid   = req_valid & sel;
  assign bus4.wdata_valid = wdata_valid & ~sel;
  assign bus0.wdata_valid = wdata_valid & sel;
  assign bus4.req_we      = req_we;
  assign bus0.req_we      = req_we;
  assign bus4.req_addr    = req_addr;
  assign bus0.req_addr    = req_addr;
  assign bus4.wdata       = wdata;
  assign bus0.wdata       = wdata;
  assign bus4.wstrb       = wstrb;
  assign bus0.wstrb       = wstrb;
  assign bus4.rsp_ready   = rsp_ready;
  assign bus0.rsp_ready   = rsp_ready;

  assign req_ready_o   = sel ? bus0.req_ready   : bus4.req_ready;
  assign wdata_ready_o = sel ? bus0.wdata_ready : bus4.wdata_ready;
  assign rsp_valid_o   = sel ? bus0.rsp_valid   : bus4.rsp_valid;
  assign rsp_data_o    = sel ? bus0.rsp_data    : bus4.rsp_data;
  assign rsp_last_o    = sel ? bus0.rsp_last    : bus4.rsp_last;
  assign wr_done_o     = sel ? bus0.wr_done     : bus4.wr_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Word slot per the addressing rule: line index modulo store size, 8 words per line.
  function automatic int slot_of(input logic [31:0] addr, input int beat);
    return int'((addr / 32) % 1024) * 8 + beat;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic accept(input logic we, input logic [31:0] addr);
    int t;
    t = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    while (!req_ready_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("accept_bound", t < 50, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Sends nbeats of wd/ws; a full line also checks the single wr_done pulse.
  task automatic do_write(input logic [31:0] addr, input int nbeats, input bit gaps);
    int i, t, n;
    accept(1'b1, addr);
    i = 0;
    t = 0;
    while (i < nbeats && t < 300) begin
      @(negedge clk);
      t++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        wdata_valid = 1'b0;
      end else begin
        wdata_valid = 1'b1;
        wdata       = wd[i];
        wstrb       = ws[i];
        if (wdata_ready_o) begin
          mem_m[sel][slot_of(addr, i)] = merge(mem_m[sel][slot_of(addr, i)], wd[i], ws[i]);
          i++;
        end
      end
    end
    chk("write_bound", i, nbeats);
    if (nbeats == 8) begin
      @(negedge clk);
      wdata_valid = 1'b0;
      n = 0;
      for (int k = 0; k < 3; k++) begin
        if (wr_done_o) n++;
        if (k < 2) @(negedge clk);
      end
      chk("wr_done_pulses", n, 1);
      chk("req_ready_after_wb", req_ready_o, 1);
    end
  endtask

  // mode 0: rsp_ready held high; 1: pattern 1,0,0,1; 2: random.
  task automatic do_read(input logic [31:0] addr, input int mode);
    int c, i, first, lat;
    logic rdy, stalled, held_last;
    logic [31:0] held;
    lat = sel ? 0 : 4;
    accept(1'b0, addr);
    c = 0; i = 0; first = -1; stalled = 1'b0; held = '0; held_last = 1'b0;
    while (i < 8 && c < 300) begin
      @(negedge clk);
      c++;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (c % 4 == 0) || (c % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      rsp_ready = rdy;
      if (rsp_valid_o) begin
        if (first < 0) begin
          first = c;
          chk("first_beat_latency", c, lat + 1);
        end
        if (stalled) chk("stall_hold", {rsp_last_o, rsp_data_o}, {held_last, held});
        chk("rsp_data", rsp_data_o, mem_m[sel][slot_of(addr, i)]);
        chk("rsp_last", rsp_last_o, i == 7);
        held      = rsp_data_o;
        held_last = rsp_last_o;
        stalled   = !rdy;
        if (rdy) begin
          rd_beats[i] = rsp_data_o;
          i++;
        end
      end
    end
    chk("read_bound", i, 8);
    if (mode == 0) chk("burst_cycles", c - first + 1, 8);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_after_burst", rsp_valid_o, 0);
    chk("req_ready_after_burst", req_ready_o, 1);
  endtask

  task automatic fill_rand(input bit rand_strb);
    for (int k = 0; k < 8; k++) begin
      wd[k] = $urandom;
      ws[k] = rand_strb ? 4'($urandom_range(0, 15)) : 4'hF;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"},   req_ready_o,   1);
    chk({tag, "_wdata_ready"}, wdata_ready_o, 0);
    chk({tag, "_rsp_valid"},   rsp_valid_o,   0);
    chk({tag, "_rsp_last"},    rsp_last_o,    0);
    chk({tag, "_wr_done"},     wr_done_o,     0);
    chk({tag, "_rsp_data"},    rsp_data_o,    0);
  endtask

  initial begin
    logic [31:0] a;
    n_checks = 0; n_pass = 0;
    rst = 1'b1; sel = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    wdata_valid = 1'b0; wdata = '0; wstrb = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Preloaded line read at READ_LAT=4 with rsp_ready held high.
    fill_rand(1'b0);
    do_write(32'h40, 8, 1'b0);
    do_read(32'h40, 0);

    // Full-strobe writeback then readback.
    for (int k = 0; k < 8; k++) begin wd[k] = 32'hA0 + k; ws[k] = 4'hF; end
    do_write(32'h1000, 8, 1'b0);
    do_read(32'h1000, 0);
    for (int k = 0; k < 8; k++) chk("wb_readback", rd_beats[k], 32'hA0 + k);

    // Partial strobes on beat 3 only.
    for (int k = 0; k < 8; k++) begin wd[k] = 32'hFFFF_FFFF; ws[k] = 4'hF; end
    do_write(32'h20, 8, 1'b0);
    for (int k = 0; k < 8; k++) begin wd[k] = $urandom; ws[k] = 4'h0; end
    wd[3] = 32'h1234_5678; ws[3] = 4'b0101;
    do_write(32'h20, 8, 1'b0);
    do_read(32'h20, 0);
    chk("partial_word3", rd_beats[3], 32'hFF34_FF78);
    chk("partial_word2", rd_beats[2], 32'hFFFF_FFFF);

    // Backpressure on refill and gaps on writeback.
    fill_rand(1'b0);
    do_write(32'h3A0, 8, 1'b1);
    fill_rand(1'b1);
    do_write(32'h3A0, 8, 1'b1);
    do_read(32'h3A0, 1);
    do_read(32'h3A0, 2);

    // Aliasing above the store and offset bits within the line.
    do_read(32'd1024 * 32 + 32'h20, 0);
    chk("alias_word3", rd_beats[3], 32'hFF34_FF78);
    do_read(32'h3F, 2);
    chk("offset_word3", rd_beats[3], 32'hFF34_FF78);

    // Reset in the middle of a writeback.
    fill_rand(1'b0);
    do_write(32'h800, 8, 1'b0);
    fill_rand(1'b0);
    do_write(32'h800, 3, 1'b0);
    @(negedge clk);
    wdata_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midburst_reset");
    rst = 1'b0;
    do_read(32'h800, 0);

    // Randomized traffic over a few preloaded lines with aliasing and offsets.
    for (int k = 0; k < 3; k++) begin
      fill_rand(1'b0);
      do_write(32'h100 + 32'(k) * 32'h40, 8, 1'b0);
    end
    for (int n = 0; n < 12; n++) begin
      a = 32'h100 + 32'($urandom_range(0, 2)) * 32'h40
          + 32'($urandom_range(0, 3)) * 32'd32768 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) begin
        fill_rand(1'b1);
        do_write(a, 8, 1'b1);
      end else begin
        do_read(a, $urandom_range(0, 2));
      end
    end

    // Zero read latency instance.
    sel = 1'b1;
    @(negedge clk);
    fill_rand(1'b0);
    do_write(32'h60, 8, 1'b0);
    do_read(32'h60, 0);
    do_read(32'd1024 * 32 + 32'h7F, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
